axis_pattern_gen: RTL and testbench
===================================

Name: axis_pattern_gen

Overview:
- AXI4-Stream master source for the AXI4_Stream IP. Sits directly downstream of the IP's AXI4-Lite register bank and consumes its slv_reg0..3 contents: control, length, seed and mode.
- On a start pulse it emits one packet of cfg_len beats in counter, LFSR or constant pattern, with TLAST on the final beat. It then reports done and returns to idle.
- Feeds the stream consumer or DMA under test.

Parameters:
- DATA_WIDTH, 32, TDATA width in bits; multiple of 8, >= 32.
- LEN_WIDTH, 16, width of the beat-count field.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- cfg_start  in  1  single-cycle start pulse, from a self-clearing bit in slv_reg0.
- cfg_len  in  LEN_WIDTH  beats per packet, from slv_reg1.
- cfg_seed  in  32  first-beat value / LFSR seed, from slv_reg2.
- cfg_mode  in  2  pattern select, from slv_reg3: 0 counter, 1 LFSR, 2 constant, 3 reserved (behaves as constant).
- busy  out  1  high from the accepted start until the last handshake.
- done  out  1  one-cycle pulse at end of packet.
- M_AXIS_TDATA  out  DATA_WIDTH  stream data.
- M_AXIS_TKEEP  out  DATA_WIDTH/8  constant all-ones.
- M_AXIS_TLAST  out  1  marks the final beat.
- M_AXIS_TVALID  out  1  data valid.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset values: busy=0, done=0, TVALID=0, TLAST=0, TDATA=0; FSM=IDLE; beat counter=0. Reset is asynchronous on assertion and released synchronously into IDLE.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_start=1 with cfg_len!=0: latch len, seed and mode; load beat0 = seed zero-extended to DATA_WIDTH; go to RUN. TVALID and busy rise on the next cycle (1-cycle start latency).
  - cfg_start=1 with cfg_len=0: no beats; go to DONE; busy stays 0.
- RUN:
  - TVALID=1 throughout.
  - Handshake = TVALID & TREADY. On each handshake the beat counter increments and the next value loads.
  - TDATA and TLAST hold stable while TVALID & !TREADY (AXI-Stream rule). TVALID never deasserts mid-packet.
  - TLAST=1 exactly when beat counter = len-1; TLAST=1 on the only beat when len=1.
  - Handshake on the TLAST beat -> DONE; TVALID, TLAST and busy drop the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE. A start may be accepted on the cycle after done.
- Pattern rules:
  - Counter: beat n = seed + n mod 2^32, zero-extended.
  - LFSR: 32-bit Galois, right shift, taps mask 0x80200003, applied when lsb=1. Seed 0 is replaced by 1. The value advances per handshake.
  - Constant: every beat = seed.
- cfg_start while busy or in DONE: ignored; latched config is unaffected.
- cfg_len, cfg_seed and cfg_mode changes during RUN are ignored; only the latched copies are used.
- Max packet = 2^LEN_WIDTH-1 beats. The beat counter never wraps within a packet.
- ARESETN low mid-packet: TVALID drops immediately (asynchronous); no TLAST and no done are emitted; the packet is truncated.

Optional Feature:
- Macro: AXIS_PATTERN_GEN_STATS_EN.
- Defined: adds outputs stat_pkts (32) and stat_stalls (32), both reset to 0.
  - stat_pkts increments on each TLAST handshake.
  - stat_stalls increments each cycle with TVALID & !TREADY.
  - Both saturate at 0xFFFFFFFF.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package axis_pattern_gen_pkg holds:
  - the mode_e enum (MODE_CNT=0, MODE_LFSR=1, MODE_CONST=2);
  - the state_e enum (IDLE, RUN, DONE);
  - LFSR_TAPS = 32'h80200003;
  - function lfsr_next.
- One sub-module: axis_pattern_gen_lfsr, a 32-bit Galois LFSR with load/advance enables.
- FSM, counter and stream regs stay in the top module.

Test Plan:
- Counter, basic: mode 0, seed 0x10, len 4, TREADY=1.
  - TDATA 0x10,0x11,0x12,0x13 on consecutive cycles; TLAST only on 0x13.
  - done pulses one cycle after the last handshake; busy high for 4 cycles.
- Backpressure: same config with TREADY toggling 1,0,0,1,...
  - TDATA and TLAST hold while stalled; exactly 4 handshakes.
  - With STATS_EN, stat_stalls equals the count of stalled cycles.
- LFSR, seed 1, len 3: TDATA 0x00000001, 0x80200003, 0xC0300002.
- LFSR, seed 0, len 1: first beat 0x00000001 with TLAST=1.
- Edge cases:
  - len=0: no TVALID; done pulses once.
  - cfg_start during RUN: ignored, packet length unchanged.
  - Start on the cycle after done: accepted.
- Reset mid-packet: ARESETN low during beat 2 of 8.
  - TVALID=0 asynchronously; all outputs at reset values.
  - After release, a new start with len 2 produces a clean 2-beat packet.

Source files
------------

// File: rtl/axis_pattern_gen_pkg.sv
// Shared types, constants and helpers for the AXI4-Stream pattern generator.
package axis_pattern_gen_pkg;

  // Pattern select as written into slv_reg3; encoding 3 behaves as constant.
  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2
  } mode_e;

  // Packet sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Galois feedback mask, XORed in after the right shift when the lsb was 1.
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // One step of the 32-bit right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] shifted;
    shifted = v >> 1;
    return v[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/axis_pattern_gen_lfsr.sv
// 32-bit Galois LFSR holding the current LFSR beat value.
// load has priority over advance; the loaded value must be non-zero.
module axis_pattern_gen_lfsr
  import axis_pattern_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        advance,
  output logic [31:0] value
);

  // Register update: load a new seed or step once per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= 32'd1;
    end else if (load) begin
      value <= load_value;
    end else if (advance) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream pattern source: on cfg_start emits one packet of cfg_len beats
// in counter, LFSR or constant pattern, then pulses done.
// Optional statistics counters are built when AXIS_PATTERN_GEN_STATS_EN is defined.
module axis_pattern_gen
  import axis_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cfg_start,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [31:0]             cfg_seed,
  input  logic [1:0]              cfg_mode,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output state_e                  dbg_state
`ifdef AXIS_PATTERN_GEN_STATS_EN
  ,
  output logic [31:0]             stat_pkts,
  output logic [31:0]             stat_stalls
`endif
);

  // Stream handshake: a beat transfers on a rising edge where TVALID and
  // TREADY are both high. Once TVALID is raised it stays high, with TDATA
  // and TLAST frozen, until that beat transfers; TVALID never drops inside
  // a packet. TREADY may change freely and is never used to form TVALID.

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt_q;
  logic [1:0]           mode_q;
  logic [31:0]          data_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 handshake;
  logic                 start_accept;
  logic [31:0]          lfsr_seed;
  logic [31:0]          lfsr_value;
  logic [31:0]          data_next;
  logic                 lfsr_advance;

  assign handshake    = tvalid_q & M_AXIS_TREADY;
  assign start_accept = (state_q == IDLE) && cfg_start && (cfg_len != '0);
  // An all-zero LFSR state would lock up, so seed 0 is promoted to 1.
  assign lfsr_seed    = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
  assign lfsr_advance = (state_q == RUN) && handshake && (mode_q == MODE_LFSR);

  axis_pattern_gen_lfsr u_lfsr (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .load       (start_accept),
    .load_value (lfsr_seed),
    .advance    (lfsr_advance),
    .value      (lfsr_value)
  );

  // Value for the beat following the current one, chosen by latched mode.
  always_comb begin
    data_next = data_q;
    case (mode_q)
      MODE_CNT:  data_next = data_q + 32'd1;
      MODE_LFSR: data_next = lfsr_next(lfsr_value);
      default:   data_next = data_q;
    endcase
  end

  // Packet sequencer with registered stream and status outputs.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      mode_q     <= 2'd0;
      data_q     <= 32'd0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_len != '0) begin
              state_q    <= RUN;
              len_q      <= cfg_len;
              mode_q     <= cfg_mode;
              beat_cnt_q <= '0;
              data_q     <= (cfg_mode == MODE_LFSR) ? lfsr_seed : cfg_seed;
              tvalid_q   <= 1'b1;
              tlast_q    <= (cfg_len == LEN_WIDTH'(1));
              busy_q     <= 1'b1;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (handshake) begin
            if (tlast_q) begin
              state_q  <= DONE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              beat_cnt_q <= beat_cnt_q + LEN_WIDTH'(1);
              data_q     <= data_next;
              tlast_q    <= ((beat_cnt_q + LEN_WIDTH'(1)) == (len_q - LEN_WIDTH'(1)));
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign M_AXIS_TDATA  = DATA_WIDTH'(data_q);
  assign M_AXIS_TKEEP  = '1;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign dbg_state     = state_q;

`ifdef AXIS_PATTERN_GEN_STATS_EN
  // Saturating counters of completed packets and back-pressured cycles.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stat_pkts   <= 32'd0;
      stat_stalls <= 32'd0;
    end else begin
      if (handshake && tlast_q && (stat_pkts != 32'hFFFFFFFF)) begin
        stat_pkts <= stat_pkts + 32'd1;
      end
      if (tvalid_q && !M_AXIS_TREADY && (stat_stalls != 32'hFFFFFFFF)) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Self-checking bench for axis_pattern_gen (default 32-bit data, 16-bit length).
// Build with AXIS_PATTERN_GEN_STATS_EN defined to also check the statistics outputs.
module tb_axis_pattern_gen;
  import axis_pattern_gen_pkg::*;

  localparam int DW = 32;
  localparam int LW = 16;

  // ---------------- clock / reset ----------------
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          cfg_start = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [31:0]   cfg_seed = '0;
  logic [1:0]    cfg_mode = '0;
  logic          busy, done;
  logic [DW-1:0] M_AXIS_TDATA;
  logic [DW/8-1:0] M_AXIS_TKEEP;
  logic          M_AXIS_TLAST, M_AXIS_TVALID;
  logic          M_AXIS_TREADY = 1'b1;
  state_e        dbg_state;
`ifdef AXIS_PATTERN_GEN_STATS_EN
  logic [31:0]   stat_pkts, stat_stalls;
`endif

  axis_pattern_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .cfg_start     (cfg_start),
    .cfg_len       (cfg_len),
    .cfg_seed      (cfg_seed),
    .cfg_mode      (cfg_mode),
    .busy          (busy),
    .done          (done),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .dbg_state     (dbg_state)
`ifdef AXIS_PATTERN_GEN_STATS_EN
    ,
    .stat_pkts     (stat_pkts),
    .stat_stalls   (stat_stalls)
`endif
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int hs_count = 0;
  int pkt_count = 0;
  int stall_count = 0;
  int ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0, 2: random
  int rdy_phase = 0;

  // Scoreboard entries: {tlast, tdata}
  logic [DW:0] exp_q[$];

  // TREADY driver, changes shortly after each rising edge.
  initial begin
    forever begin
      @(posedge ACLK);
      #2;
      case (ready_mode)
        0: M_AXIS_TREADY = 1'b1;
        1: begin
          M_AXIS_TREADY = (rdy_phase == 0);
          rdy_phase = (rdy_phase + 1) % 3;
        end
        default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor: pops the scoreboard on every handshake and checks
  // that a stalled beat is held unchanged into the next cycle.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_data || M_AXIS_TLAST !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: got valid=%b data=%h last=%b, need valid=1 data=%h last=%b",
                   M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, prev_data, prev_last);
        end
      end
      if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got data=%h last=%b, need no beat", M_AXIS_TDATA, M_AXIS_TLAST);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          if ({M_AXIS_TLAST, M_AXIS_TDATA} !== e) begin
            bad++;
            $display("FAIL beat: got last=%b data=%h, need last=%b data=%h",
                     M_AXIS_TLAST, M_AXIS_TDATA, e[DW], e[DW-1:0]);
          end
        end
        hs_count++;
        if (M_AXIS_TLAST === 1'b1) pkt_count++;
      end
      prev_stall = (M_AXIS_TVALID === 1'b1) && (M_AXIS_TREADY !== 1'b1);
      if (prev_stall) stall_count++;
      prev_data = M_AXIS_TDATA;
      prev_last = M_AXIS_TLAST;
    end
  end

  // Watchdog in case a bound below is missed.
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Fills the scoreboard for a packet, pulses cfg_start at the current
  // negedge and returns at the negedge after the start was sampled.
  task automatic start_pkt(input logic [1:0] mode, input logic [31:0] seed, input int len);
    logic [31:0] v;
    logic fb;
    v = seed;
    if (mode == 2'd1 && seed == 32'd0) v = 32'd1;
    for (int n = 0; n < len; n++) begin
      exp_q.push_back({(n == len - 1), DW'(v)});
      case (mode)
        2'd0: v = v + 32'd1;
        2'd1: begin
          fb = v[0];
          v = {1'b0, v[31:1]};
          if (fb) v = v ^ 32'h80200003;
        end
        default: v = v;
      endcase
    end
    cfg_mode  = mode;
    cfg_seed  = seed;
    cfg_len   = LW'(len);
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    if (len != 0) begin
      total++;
      if (M_AXIS_TVALID !== 1'b1 || busy !== 1'b1) begin
        bad++;
        $display("FAIL start_latency: got valid=%b busy=%b, need valid=1 busy=1", M_AXIS_TVALID, busy);
      end
    end
  endtask

  // Waits (bounded) for done; reports busy cycles seen from the current negedge.
  task automatic wait_done(input string name, input int budget, output int busy_cycles);
    bit seen;
    seen = (done === 1'b1);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge ACLK);
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done_timeout: got no done in %0d cycles, need done", name, budget);
    end else begin
      total++;
      if (exp_q.size() != 0 || M_AXIS_TVALID !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s_at_done: got pending=%0d valid=%b busy=%b, need 0 0 0",
                 name, exp_q.size(), M_AXIS_TVALID, busy);
      end
      @(negedge ACLK);
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL %s_done_width: got done=%b, need 0", name, done);
      end
    end
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    exp_q.delete();
    hs_count = 0;
    pkt_count = 0;
    stall_count = 0;
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || M_AXIS_TVALID !== 1'b0 || M_AXIS_TLAST !== 1'b0 ||
        M_AXIS_TDATA !== '0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL %s: got busy=%b done=%b valid=%b last=%b data=%h state=%0d, need all 0 / IDLE",
               name, busy, done, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, dbg_state);
    end
`ifdef AXIS_PATTERN_GEN_STATS_EN
    total++;
    if (stat_pkts !== 32'd0 || stat_stalls !== 32'd0) begin
      bad++;
      $display("FAIL %s_stats: got pkts=%0d stalls=%0d, need 0 0", name, stat_pkts, stat_stalls);
    end
`endif
  endtask

  task automatic check_stats(input string name);
`ifdef AXIS_PATTERN_GEN_STATS_EN
    total++;
    if (stat_pkts !== 32'(pkt_count) || stat_stalls !== 32'(stall_count)) begin
      bad++;
      $display("FAIL %s_stats: got pkts=%0d stalls=%0d, need %0d %0d",
               name, stat_pkts, stat_stalls, pkt_count, stall_count);
    end
`else
    if (name.len() == 0) $display("empty stats name");
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    repeat (3) @(negedge ACLK);
    check_reset_values("reset_held");
    total++;
    if (M_AXIS_TKEEP !== '1) begin
      bad++;
      $display("FAIL tkeep: got %h, need all ones", M_AXIS_TKEEP);
    end
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check_reset_values("reset_released");
  endtask

  task automatic test_counter_basic();
    int bc;
    ready_mode = 0;
    @(negedge ACLK);
    start_pkt(2'd0, 32'h10, 4);
    wait_done("counter", 20, bc);
    total++;
    if (bc != 4) begin
      bad++;
      $display("FAIL counter_busy_cycles: got %0d, need 4", bc);
    end
    check_stats("counter");
  endtask

  task automatic test_backpressure();
    int bc, hs0;
    hs0 = hs_count;
    rdy_phase = 0;
    ready_mode = 1;
    repeat (2) @(negedge ACLK);
    start_pkt(2'd0, 32'h10, 4);
    wait_done("backpressure", 40, bc);
    total++;
    if (hs_count - hs0 != 4) begin
      bad++;
      $display("FAIL backpressure_handshakes: got %0d, need 4", hs_count - hs0);
    end
    ready_mode = 0;
    check_stats("backpressure");
  endtask

  task automatic test_lfsr();
    int bc;
    ready_mode = 0;
    @(negedge ACLK);
    start_pkt(2'd1, 32'd1, 3);
    wait_done("lfsr_seed1", 20, bc);
    @(negedge ACLK);
    start_pkt(2'd1, 32'd0, 1);
    wait_done("lfsr_seed0", 20, bc);
    total++;
    if (bc != 1) begin
      bad++;
      $display("FAIL lfsr_len1_busy: got %0d, need 1", bc);
    end
  endtask

  task automatic test_len_zero();
    int dones, valids, busys;
    dones = 0; valids = 0; busys = 0;
    @(negedge ACLK);
    start_pkt(2'd0, 32'h55, 0);
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) dones++;
      if (M_AXIS_TVALID === 1'b1) valids++;
      if (busy === 1'b1) busys++;
      @(negedge ACLK);
    end
    total++;
    if (dones != 1 || valids != 0 || busys != 0) begin
      bad++;
      $display("FAIL len_zero: got done=%0d valid=%0d busy=%0d cycles, need 1 0 0", dones, valids, busys);
    end
  endtask

  task automatic test_start_during_run();
    int bc, hs0;
    hs0 = hs_count;
    ready_mode = 1;
    rdy_phase = 0;
    @(negedge ACLK);
    start_pkt(2'd2, 32'hCAFE0001, 4);
    @(negedge ACLK);
    cfg_len = LW'(7);
    cfg_seed = 32'h1234;
    cfg_mode = 2'd0;
    cfg_start = 1'b1;
    @(negedge ACLK);
    cfg_start = 1'b0;
    wait_done("start_in_run", 40, bc);
    repeat (3) @(negedge ACLK);
    total++;
    if (hs_count - hs0 != 4 || M_AXIS_TVALID !== 1'b0) begin
      bad++;
      $display("FAIL start_in_run_len: got %0d beats valid=%b, need 4 beats valid=0",
               hs_count - hs0, M_AXIS_TVALID);
    end
    ready_mode = 0;
  endtask

  task automatic test_back_to_back();
    int bc;
    ready_mode = 0;
    @(negedge ACLK);
    start_pkt(2'd0, 32'hFFFFFFFE, 3);   // counter wraps at 2^32
    wait_done("b2b_first", 20, bc);     // returns the cycle after done
    start_pkt(2'd3, 32'hA5A5A5A5, 2);   // reserved mode acts as constant
    wait_done("b2b_second", 20, bc);
    check_stats("b2b");
  endtask

  task automatic test_random();
    int bc;
    ready_mode = 2;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      start_pkt(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 9));
      wait_done("random", 200, bc);
    end
    ready_mode = 0;
    check_stats("random");
  endtask

  task automatic test_reset_mid_packet();
    int bc;
    ready_mode = 0;
    @(negedge ACLK);
    start_pkt(2'd0, 32'h100, 8);
    repeat (2) @(negedge ACLK);
    #1;
    apply_reset();
    #1;
    check_reset_values("reset_mid_packet");
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_reset_values("reset_mid_released");
    start_pkt(2'd0, 32'h5, 2);
    wait_done("after_reset", 20, bc);
    total++;
    if (hs_count != 2 || pkt_count != 1) begin
      bad++;
      $display("FAIL after_reset_pkt: got %0d beats %0d pkts, need 2 1", hs_count, pkt_count);
    end
    check_stats("after_reset");
  endtask

  initial begin
    test_reset();
    test_counter_basic();
    test_backpressure();
    test_lfsr();
    test_len_zero();
    test_start_during_run();
    test_back_to_back();
    test_random();
    test_reset_mid_packet();
    repeat (2) @(negedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
